pixels_to_vector: RTL
=====================

Name: pixels_to_vector

Overview:
- Capture side of the 48-bit digit image path, and the inverse of the vector-to-pixel renderer.
- Takes one raster-order grayscale frame from a pixel stream and splits it into an 8-column x 6-row grid of cells.
- Binarizes each cell by its ink-pixel count and packs the result into the 48-bit test vector consumed by the digit recognizer.
- Output uses a valid/ready handshake so the recognizer's start can be driven directly from vec_valid & vec_ready.

Parameters:
- IMG_W, 64, active pixels per line; must be a multiple of 8.
- IMG_H, 48, active lines per frame; must be a multiple of 6.
- PIX_THRESH, 128, 8-bit gray threshold that defines an ink pixel.
- INK_DARK, 1, 1: ink when pix_data < PIX_THRESH; 0: ink when pix_data >= PIX_THRESH.
- CELL_THRESH, 16, minimum ink-pixel count for a cell bit to be 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- arm  in  1  one-cycle request to capture the next frame
- pix_valid  in  1  pixel present this cycle
- pix_sof  in  1  first pixel of a frame; qualified by pix_valid
- pix_data  in  8  grayscale pixel
- busy  out  1  high from arm acceptance until vec_valid asserts
- vec_valid  out  1  vec_48 holds a completed frame
- vec_ready  in  1  consumer accepts vec_48
- vec_48  out  48  packed binary image
- sof_err  out  1  one-cycle pulse when pix_sof arrives mid-capture

Behaviour:
- Derived constants: CW = IMG_W/8, CH = IMG_H/6. Cell counter width = clog2(CW*CH+1).
- Reset values: busy=0, vec_valid=0, vec_48=0, sof_err=0. All counters clear; state = IDLE.
- State IDLE:
  - arm -> ARMED. busy=1.
  - pixels are ignored.
- State ARMED:
  - waits for pix_valid & pix_sof; that pixel is processed as x=0, y=0.
  - transitions -> CAPTURE.
- State CAPTURE:
  - On each pix_valid, ink = INK_DARK ? (pix_data < PIX_THRESH) : (pix_data >= PIX_THRESH).
  - col = x / CW. If ink, cnt[col] increments. There are 8 column counters, shared across one cell row.
  - x wraps at IMG_W-1 and y increments.
  - On the last pixel of the last line of a cell row (x = IMG_W-1, y mod CH = CH-1), in the same cycle:
    - bit[47 - (row*8 + col)] = (cnt[col] + ink_this_pixel_if_col7 >= CELL_THRESH) for all 8 columns;
    - all counters clear.
  - Cell (0,0), top-left, maps to vec_48[47]; cell (5,7), bottom-right, maps to vec_48[0].
  - After the last frame pixel (x = IMG_W-1, y = IMG_H-1), the next cycle has vec_valid=1, busy=0, and state -> HOLD.
  - Latency: 1 cycle from the last pixel to vec_valid.
  - pix_valid low: counters and positions hold, so stalls of any length are allowed.
  - pix_sof during CAPTURE with x,y != 0,0:
    - sof_err pulses for 1 cycle;
    - counters and the partial vector clear;
    - the pixel is taken as the new (0,0). Capture restarts with no return to ARMED.
  - pix_sof without pix_valid is ignored.
- State HOLD:
  - vec_48 and vec_valid stay stable until vec_valid & vec_ready.
  - The handshake cycle clears vec_valid and moves -> IDLE.
  - Pixels are ignored.
  - An arm in the same cycle as the handshake goes directly -> ARMED.
  - An arm while in HOLD without vec_ready is dropped.
- arm in ARMED or CAPTURE has no effect.
- vec_48 updates only on frame completion. Bits for partially captured cell rows are never exposed.
- rst in any state returns to the reset values on the next edge. rst has priority over every other input.

Test Plan:
- All pixels 0x00, INK_DARK=1, arm then a 64x48 frame -> vec_valid exactly 1 cycle after the last pixel; vec_48=48'hFFFF_FFFF_FFFF; busy falls the same cycle.
- Only cell (0,0) dark (x<8, y<8 = 0x10, rest 0xFF) -> vec_48=48'h8000_0000_0000. Repeat with only cell (5,7) dark -> 48'h0000_0000_0001.
- Cell (2,3) holding exactly 16 dark pixels -> bit 47-19=28 set. With 15 dark pixels -> vec_48=0.
- Random pix_valid gaps (about 50% duty) with the same image as the (2,3) case -> identical vec_48. vec_valid is held for 5 cycles while vec_ready=0 and vec_48 stays stable.
- pix_sof at pixel index 1000, then a full all-dark frame -> sof_err is a single 1-cycle pulse; final vec_48 = all ones.
- rst asserted mid-frame -> next cycle busy=0, vec_valid=0, vec_48=0. A frame without a new arm produces no vec_valid.

Source files
------------

// File: rtl/pixels_to_vector.sv
// rtl/pixels_to_vector.sv - capture one raster frame and binarize it into an 8x6 cell vector
module pixels_to_vector #(
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 48,
    parameter int PIX_THRESH  = 128,
    parameter int INK_DARK    = 1,
    parameter int CELL_THRESH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [7:0]  pix_data,
    output logic        busy,
    output logic        vec_valid,
    input  logic        vec_ready,
    output logic [47:0] vec_48,
    output logic        sof_err
);
    localparam int CW   = IMG_W / 8;
    localparam int CH   = IMG_H / 6;
    localparam int CNTW = $clog2(CW * CH + 1);
    localparam int XW   = (CW > 1) ? $clog2(CW) : 1;
    localparam int YW   = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;
    state_t state, state_n;

    // Position is tracked as (sub-column, cell column, sub-row, cell row) to avoid dividers.
    logic [XW-1:0]        x_sub, x_n, cx;
    logic [2:0]           col, col_n, ccol;
    logic [YW-1:0]        y_sub, y_n, cy;
    logic [2:0]           row, row_n, crow;
    logic [7:0][CNTW-1:0] cnt, cnt_n, ccnt;
    logic [47:0]          part, part_n, cpart, vec_n;
    logic                 busy_n, valid_n, sof_err_n;
    logic                 ink, pos_nz, sof_hit, restart, take;
    logic                 line_end, row_end, frame_end;
    logic [7:0]           row_byte;

    always_comb begin
        ink       = (INK_DARK != 0) ? (int'(pix_data) < PIX_THRESH) : (int'(pix_data) >= PIX_THRESH);
        pos_nz    = (x_sub != '0) || (col != '0) || (y_sub != '0) || (row != '0);
        sof_hit   = pix_valid && pix_sof;
        restart   = sof_hit && ((state == ARMED) || ((state == CAPTURE) && pos_nz));
        take      = pix_valid && ((state == CAPTURE) || ((state == ARMED) && pix_sof));
        sof_err_n = sof_hit && (state == CAPTURE) && pos_nz;

        // A (re)start pixel sees a cleared position, counters and partial vector.
        cx    = restart ? '0 : x_sub;
        ccol  = restart ? '0 : col;
        cy    = restart ? '0 : y_sub;
        crow  = restart ? '0 : row;
        ccnt  = restart ? '0 : cnt;
        cpart = restart ? '0 : part;

        line_end  = (cx == XW'(CW - 1)) && (ccol == 3'd7);
        row_end   = line_end && (cy == YW'(CH - 1));
        frame_end = row_end && (crow == 3'd5);

        for (int c = 0; c < 8; c++) begin
            row_byte[7-c] = (int'(ccnt[c]) + (((c == 7) && ink) ? 1 : 0)) >= CELL_THRESH;
        end

        x_n    = x_sub;
        col_n  = col;
        y_n    = y_sub;
        row_n  = row;
        cnt_n  = cnt;
        part_n = part;
        vec_n  = vec_48;

        if (take) begin
            x_n    = cx;
            col_n  = ccol;
            y_n    = cy;
            row_n  = crow;
            cnt_n  = ccnt;
            part_n = cpart;
            if (ink) begin
                cnt_n[ccol] = ccnt[ccol] + CNTW'(1);
            end

            if (cx == XW'(CW - 1)) begin
                x_n = '0;
                if (ccol == 3'd7) begin
                    col_n = '0;
                    if (cy == YW'(CH - 1)) begin
                        y_n   = '0;
                        row_n = (crow == 3'd5) ? 3'd0 : crow + 3'd1;
                    end else begin
                        y_n = cy + YW'(1);
                    end
                end else begin
                    col_n = ccol + 3'd1;
                end
            end else begin
                x_n = cx + XW'(1);
            end

            if (row_end) begin
                for (int r = 0; r < 6; r++) begin
                    if (crow == 3'(r)) begin
                        part_n[47-8*r -: 8] = row_byte;
                    end
                end
                cnt_n = '0;
            end
            if (frame_end) begin
                vec_n  = part_n;
                part_n = '0;
            end
        end

        state_n = state;
        busy_n  = busy;
        valid_n = vec_valid;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_n = ARMED;
                    busy_n  = 1'b1;
                end
            end
            ARMED: begin
                if (take) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (take && frame_end) begin
                    state_n = HOLD;
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            HOLD: begin
                if (vec_ready) begin
                    valid_n = 1'b0;
                    if (arm) begin
                        state_n = ARMED;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            vec_valid <= 1'b0;
            vec_48    <= '0;
            sof_err   <= 1'b0;
            x_sub     <= '0;
            col       <= '0;
            y_sub     <= '0;
            row       <= '0;
            cnt       <= '0;
            part      <= '0;
        end else begin
            state     <= state_n;
            busy      <= busy_n;
            vec_valid <= valid_n;
            vec_48    <= vec_n;
            sof_err   <= sof_err_n;
            x_sub     <= x_n;
            col       <= col_n;
            y_sub     <= y_n;
            row       <= row_n;
            cnt       <= cnt_n;
            part      <= part_n;
        end
    end
endmodule
